// File: rtl/cfg_lut_pkg.sv
// Shared types and sizing helpers for the reconfigurable LUT bank.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package cfg_lut_pkg;

    // Loader sequencing states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        ARMED = 2'd2
    } cfg_state_e;

    // Truth-table width for a k-input LUT.
    function automatic int tbl_w(input int k);
        return 1 << k;
    endfunction

    // Width of a channel index; never narrower than one bit.
    function automatic int chan_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lut_channel.sv
// One LUT channel: serially written shadow table, atomically loaded active table, K-bit mux.
// Latency: 1 cycle when REGISTERED, else combinational from the active table.
// Backpressure: none; writes and commits are accepted whenever enabled.
module lut_channel
    import cfg_lut_pkg::*;
#(
    parameter int                  K          = 4,
    parameter bit                  REGISTERED = 1'b1,
    parameter logic [tbl_w(K)-1:0] RESET_LUT  = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [K-1:0] lut_in_i,
    input  logic         wr_en_i,
    input  logic [K-1:0] wr_idx_i,
    input  logic         wr_bit_i,
    input  logic         commit_i,
    output logic         lut_out_o
);

    localparam int TW = tbl_w(K);

    logic [TW-1:0] shadow_q, shadow_d;
    logic [TW-1:0] active_q, active_d;
    logic          eval_bit;

    // Serial write of one shadow bit.
    always_comb begin
        shadow_d = shadow_q;
        if (wr_en_i) begin
            shadow_d[wr_idx_i] = wr_bit_i;
        end
    end

    // Whole-table swap on commit so evaluation never sees a partial table.
    always_comb begin
        active_d = commit_i ? shadow_q : active_q;
    end

    // Table storage; reset discards any partial or uncommitted load.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow_q <= '0;
            active_q <= RESET_LUT;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
        end
    end

    assign eval_bit = active_q[lut_in_i];

    generate
        if (REGISTERED) begin : g_reg
            logic out_q;

            // Registered evaluation result.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    out_q <= 1'b0;
                end else begin
                    out_q <= eval_bit;
                end
            end

            assign lut_out_o = out_q;
        end else begin : g_comb
            assign lut_out_o = eval_bit;
        end
    endgenerate

endmodule

// File: rtl/cfg_lut_bank.sv
// Bank of N runtime-loadable K-input LUTs with serial shadow load and atomic multi-channel commit.
// Latency: lut_out 1 cycle after lut_in when REGISTERED, else combinational; new tables visible the cycle after commit.
// Backpressure: serial loader stalls on cfg_bit_valid low; start/commit outside their legal states are dropped.
module cfg_lut_bank
    import cfg_lut_pkg::*;
#(
    parameter int                  K          = 4,
    parameter int                  N          = 4,
    parameter bit                  REGISTERED = 1'b1,
    parameter logic [tbl_w(K)-1:0] RESET_LUT  = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N*K-1:0]       lut_in,
    output logic [N-1:0]         lut_out,
    input  logic                 cfg_start,
    input  logic [chan_w(N)-1:0] cfg_chan,
    input  logic                 cfg_bit,
    input  logic                 cfg_bit_valid,
    input  logic                 cfg_commit,
    output logic                 cfg_busy,
    output logic [N-1:0]         cfg_dirty,
    output logic                 cfg_done,
    output logic                 cfg_err
);

    localparam int             TW   = tbl_w(K);
    localparam int             CW   = chan_w(N);
    localparam int             CNTW = K + 1;
    localparam logic [CW:0]    N_L  = (CW + 1)'(N);

    cfg_state_e        state_q, state_d;
    logic [CW-1:0]     chan_q, chan_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [N-1:0]      dirty_q, dirty_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              chan_ok;
    logic              last_bit;
    logic              wr_en;
    logic              commit_en;
    logic [K-1:0]      wr_idx;
    logic [N-1:0]      chan_oh;
    logic [N-1:0]      commit_vec;

    assign chan_ok  = ({1'b0, cfg_chan} < N_L);
    assign last_bit = (cnt_q == CNTW'(TW - 1));
    // Bits arrive MSB first, so table index is TW-1-cnt, i.e. the inverted low counter bits.
    assign wr_idx   = ~cnt_q[K-1:0];

    // One-hot decode of the channel being loaded.
    always_comb begin
        chan_oh = '0;
        for (int i = 0; i < N; i++) begin
            chan_oh[i] = (chan_q == CW'(i));
        end
    end

    // Loader next-state logic: channel select, bit counter, dirty mask and status pulses.
    always_comb begin
        state_d   = state_q;
        chan_d    = chan_q;
        cnt_d     = cnt_q;
        dirty_d   = dirty_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        wr_en     = 1'b0;
        commit_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (cfg_start) begin
                    if (chan_ok) begin
                        chan_d  = cfg_chan;
                        cnt_d   = '0;
                        state_d = SHIFT;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            SHIFT: begin
                if (cfg_bit_valid) begin
                    wr_en = 1'b1;
                    if (last_bit) begin
                        dirty_d = dirty_q | chan_oh;
                        cnt_d   = '0;
                        state_d = ARMED;
                    end else begin
                        cnt_d = cnt_q + CNTW'(1);
                    end
                end
            end
            ARMED: begin
                // Commit has priority over a simultaneous start.
                if (cfg_commit) begin
                    commit_en = 1'b1;
                    dirty_d   = '0;
                    done_d    = 1'b1;
                    state_d   = IDLE;
                end else if (cfg_start) begin
                    if (chan_ok) begin
                        chan_d  = cfg_chan;
                        cnt_d   = '0;
                        state_d = SHIFT;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Loader state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            chan_q  <= '0;
            cnt_q   <= '0;
            dirty_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            chan_q  <= chan_d;
            cnt_q   <= cnt_d;
            dirty_q <= dirty_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Only dirty channels take their shadow on commit; clean ones keep their active table.
    assign commit_vec = dirty_q & {N{commit_en}};

    assign cfg_busy  = (state_q == SHIFT);
    assign cfg_dirty = dirty_q;
    assign cfg_done  = done_q;
    assign cfg_err   = err_q;

    for (genvar gi = 0; gi < N; gi++) begin : g_chan
        lut_channel #(
            .K          (K),
            .REGISTERED (REGISTERED),
            .RESET_LUT  (RESET_LUT)
        ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .lut_in_i  (lut_in[gi*K +: K]),
            .wr_en_i   (wr_en & chan_oh[gi]),
            .wr_idx_i  (wr_idx),
            .wr_bit_i  (cfg_bit),
            .commit_i  (commit_vec[gi]),
            .lut_out_o (lut_out[gi])
        );
    end

endmodule

// File: tb/tb_cfg_lut_bank.sv
// Self-checking bench for cfg_lut_bank: registered and combinational instances driven in parallel.
// Latency: n/a.
// Backpressure: n/a.
module tb_cfg_lut_bank;

    localparam int K  = 4;
    localparam int N  = 3;
    localparam int CW = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N*K-1:0]  lut_in;
    logic            cfg_start;
    logic [CW-1:0]   cfg_chan;
    logic            cfg_bit;
    logic            cfg_bit_valid;
    logic            cfg_commit;

    logic [N-1:0]    out_r, out_c;
    logic            busy_r, busy_c;
    logic [N-1:0]    dirty_r, dirty_c;
    logic            done_r, done_c;
    logic            err_r, err_c;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: tables as plain arrays, updated at the transaction level.
    logic [15:0]     act_m [N];
    logic [15:0]     sh_m  [N];
    logic [N-1:0]    dirty_m;

    always #5 clk = ~clk;

    cfg_lut_bank #(.K(K), .N(N), .REGISTERED(1'b1), .RESET_LUT(16'b0)) dut_r (
        .clk(clk), .rst_n(rst_n), .lut_in(lut_in), .lut_out(out_r),
        .cfg_start(cfg_start), .cfg_chan(cfg_chan), .cfg_bit(cfg_bit),
        .cfg_bit_valid(cfg_bit_valid), .cfg_commit(cfg_commit),
        .cfg_busy(busy_r), .cfg_dirty(dirty_r), .cfg_done(done_r), .cfg_err(err_r)
    );

    cfg_lut_bank #(.K(K), .N(N), .REGISTERED(1'b0), .RESET_LUT(16'b0)) dut_c (
        .clk(clk), .rst_n(rst_n), .lut_in(lut_in), .lut_out(out_c),
        .cfg_start(cfg_start), .cfg_chan(cfg_chan), .cfg_bit(cfg_bit),
        .cfg_bit_valid(cfg_bit_valid), .cfg_commit(cfg_commit),
        .cfg_busy(busy_c), .cfg_dirty(dirty_c), .cfg_done(done_c), .cfg_err(err_c)
    );

    function automatic logic [N-1:0] model_out(input logic [N*K-1:0] li);
        logic [N-1:0] r;
        logic [15:0]  t;
        for (int i = 0; i < N; i++) begin
            t    = act_m[i];
            r[i] = t[li[i*K +: K]];
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            act_m[i] = 16'h0;
            sh_m[i]  = 16'h0;
        end
        dirty_m = '0;
    endtask

    task automatic model_commit();
        for (int i = 0; i < N; i++) begin
            if (dirty_m[i]) act_m[i] = sh_m[i];
        end
        dirty_m = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        cfg_start     = 1'b0;
        cfg_commit    = 1'b0;
        cfg_bit_valid = 1'b0;
        cfg_bit       = 1'b0;
    endtask

    task automatic do_start(input int ch);
        cfg_start = 1'b1;
        cfg_chan  = CW'(ch);
        tick();
        cfg_start = 1'b0;
    endtask

    task automatic do_commit();
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
    endtask

    // Shifts a table MSB first, inserting `stalls` idle cycles before bit number stall_at.
    task automatic shift_table(input logic [15:0] t, input int stall_at, input int stalls);
        for (int n = 0; n < 16; n++) begin
            if (n == stall_at) begin
                for (int s = 0; s < stalls; s++) begin
                    cfg_bit_valid = 1'b0;
                    tick();
                end
            end
            cfg_bit       = t[15-n];
            cfg_bit_valid = 1'b1;
            tick();
        end
        cfg_bit_valid = 1'b0;
        cfg_bit       = 1'b0;
    endtask

    task automatic test_reset();
        idle_in();
        cfg_chan = '0;
        rst_n    = 1'b0;
        lut_in   = 12'($urandom);
        tick();
        tick();
        model_reset();
        for (int i = 0; i < 4; i++) begin
            lut_in = 12'($urandom);
            tick();
            n_cmp++;
            if (out_r !== 3'b000) begin
                n_bad++;
                $display("FAIL reset_out_r: got %b want %b", out_r, 3'b000);
            end
            n_cmp++;
            if (out_c !== 3'b000) begin
                n_bad++;
                $display("FAIL reset_out_c: got %b want %b", out_c, 3'b000);
            end
        end
        n_cmp++;
        if ({busy_r, dirty_r, done_r, err_r} !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl: got busy=%b dirty=%b done=%b err=%b want all zero",
                     busy_r, dirty_r, done_r, err_r);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_load_and();
        do_start(0);
        n_cmp++;
        if (busy_r !== 1'b1) begin
            n_bad++;
            $display("FAIL and_busy: got %b want 1", busy_r);
        end
        shift_table(16'h8000, 99, 0);
        sh_m[0] = 16'h8000;
        dirty_m[0] = 1'b1;
        n_cmp++;
        if (busy_r !== 1'b0 || dirty_r !== dirty_m) begin
            n_bad++;
            $display("FAIL and_armed: got busy=%b dirty=%b want busy=0 dirty=%b", busy_r, dirty_r, dirty_m);
        end
        lut_in      = 12'($urandom);
        lut_in[3:0] = 4'hF;
        do_commit();
        model_commit();
        n_cmp++;
        if (done_r !== 1'b1 || dirty_r !== 3'b000) begin
            n_bad++;
            $display("FAIL and_done: got done=%b dirty=%b want done=1 dirty=000", done_r, dirty_r);
        end
        tick();
        n_cmp++;
        if (done_r !== 1'b0) begin
            n_bad++;
            $display("FAIL and_done_pulse: got %b want 0", done_r);
        end
        tick();
        n_cmp++;
        if (out_r[0] !== 1'b1 || out_c[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL and_eval_F: got r=%b c=%b want 1", out_r[0], out_c[0]);
        end
        lut_in[3:0] = 4'hE;
        #1;
        n_cmp++;
        if (out_c[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL and_eval_E_comb: got %b want 0", out_c[0]);
        end
        tick();
        n_cmp++;
        if (out_r[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL and_eval_E_reg: got %b want 0", out_r[0]);
        end
    endtask

    task automatic test_load_stall();
        logic [N-1:0] exp_o;
        lut_in      = 12'($urandom);
        lut_in[7:4] = 4'h1;
        tick();
        exp_o = model_out(lut_in);
        do_start(1);
        for (int n = 0; n < 16; n++) begin
            if (n == 7) begin
                for (int s = 0; s < 3; s++) begin
                    cfg_bit_valid = 1'b0;
                    tick();
                    n_cmp++;
                    if (busy_r !== 1'b1) begin
                        n_bad++;
                        $display("FAIL stall_busy: got %b want 1 (stall %0d)", busy_r, s);
                    end
                end
            end
            cfg_bit       = 1'(16'h6996 >> (15 - n));
            cfg_bit_valid = 1'b1;
            tick();
        end
        cfg_bit_valid = 1'b0;
        sh_m[1]    = 16'h6996;
        dirty_m[1] = 1'b1;
        n_cmp++;
        if (dirty_r !== 3'b010 || out_r[1] !== exp_o[1]) begin
            n_bad++;
            $display("FAIL stall_precommit: got dirty=%b out1=%b want dirty=010 out1=%b",
                     dirty_r, out_r[1], exp_o[1]);
        end
        do_commit();
        model_commit();
        tick();
        n_cmp++;
        if (out_r[1] !== 1'b1) begin
            n_bad++;
            $display("FAIL stall_eval_1: got %b want 1", out_r[1]);
        end
        for (int v = 0; v < 16; v++) begin
            lut_in[7:4] = 4'(v);
            tick();
            exp_o = model_out(lut_in);
            n_cmp++;
            if (out_r !== exp_o || out_c !== exp_o) begin
                n_bad++;
                $display("FAIL stall_table idx=%0d: got r=%b c=%b want %b", v, out_r, out_c, exp_o);
            end
        end
    endtask

    task automatic test_err();
        cfg_start = 1'b1;
        cfg_chan  = 2'd3;
        tick();
        cfg_start = 1'b0;
        n_cmp++;
        if (err_r !== 1'b1 || busy_r !== 1'b0) begin
            n_bad++;
            $display("FAIL err_idle: got err=%b busy=%b want err=1 busy=0", err_r, busy_r);
        end
        tick();
        n_cmp++;
        if (err_r !== 1'b0) begin
            n_bad++;
            $display("FAIL err_pulse: got %b want 0", err_r);
        end
        do_start(2);
        sh_m[2] = 16'($urandom);
        shift_table(sh_m[2], 5, 2);
        dirty_m[2] = 1'b1;
        cfg_start = 1'b1;
        cfg_chan  = 2'd3;
        tick();
        cfg_start = 1'b0;
        n_cmp++;
        if (err_r !== 1'b1 || busy_r !== 1'b0 || dirty_r !== dirty_m) begin
            n_bad++;
            $display("FAIL err_armed: got err=%b busy=%b dirty=%b want err=1 busy=0 dirty=%b",
                     err_r, busy_r, dirty_r, dirty_m);
        end
        do_commit();
        model_commit();
        n_cmp++;
        if (done_r !== 1'b1) begin
            n_bad++;
            $display("FAIL err_commit_after: got done=%b want 1", done_r);
        end
    endtask

    task automatic test_start_commit();
        logic [N-1:0] exp_o;
        do_start(0);
        sh_m[0] = 16'($urandom);
        shift_table(sh_m[0], 99, 0);
        dirty_m[0] = 1'b1;
        cfg_start  = 1'b1;
        cfg_chan   = 2'd1;
        cfg_commit = 1'b1;
        tick();
        idle_in();
        model_commit();
        n_cmp++;
        if (done_r !== 1'b1 || busy_r !== 1'b0 || dirty_r !== 3'b000) begin
            n_bad++;
            $display("FAIL sc_commit_wins: got done=%b busy=%b dirty=%b want 1 0 000", done_r, busy_r, dirty_r);
        end
        // Bits offered while idle must be ignored.
        for (int n = 0; n < 20; n++) begin
            cfg_bit       = 1'($urandom);
            cfg_bit_valid = 1'b1;
            tick();
        end
        idle_in();
        n_cmp++;
        if (busy_r !== 1'b0 || dirty_r !== 3'b000) begin
            n_bad++;
            $display("FAIL sc_idle_bits: got busy=%b dirty=%b want 0 000", busy_r, dirty_r);
        end
        for (int i = 0; i < 8; i++) begin
            lut_in = 12'($urandom);
            tick();
            exp_o = model_out(lut_in);
            n_cmp++;
            if (out_r !== exp_o || out_c !== exp_o) begin
                n_bad++;
                $display("FAIL sc_eval: in=%h got r=%b c=%b want %b", lut_in, out_r, out_c, exp_o);
            end
        end
    endtask

    task automatic test_reset_mid_load();
        logic [N-1:0] exp_o;
        logic [15:0]  t;
        do_start(0);
        t = 16'($urandom);
        for (int n = 0; n < 8; n++) begin
            cfg_bit       = t[15-n];
            cfg_bit_valid = 1'b1;
            tick();
        end
        idle_in();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        model_reset();
        tick();
        n_cmp++;
        if (busy_r !== 1'b0 || dirty_r !== 3'b000) begin
            n_bad++;
            $display("FAIL rml_state: got busy=%b dirty=%b want 0 000", busy_r, dirty_r);
        end
        do_commit();
        n_cmp++;
        if (done_r !== 1'b0) begin
            n_bad++;
            $display("FAIL rml_commit_ignored: got done=%b want 0", done_r);
        end
        for (int i = 0; i < 6; i++) begin
            lut_in = 12'($urandom);
            if (i == 0) lut_in[3:0] = 4'hF;
            tick();
            exp_o = model_out(lut_in);
            n_cmp++;
            if (out_r !== exp_o || out_c !== exp_o) begin
                n_bad++;
                $display("FAIL rml_eval: in=%h got r=%b c=%b want %b", lut_in, out_r, out_c, exp_o);
            end
        end
    endtask

    task automatic test_random();
        logic [N-1:0] exp_o;
        int           ch;
        for (int r = 0; r < 8; r++) begin
            ch = $urandom_range(N - 1, 0);
            do_start(ch);
            sh_m[ch] = 16'($urandom);
            shift_table(sh_m[ch], $urandom_range(15, 0), $urandom_range(3, 0));
            dirty_m[ch] = 1'b1;
            n_cmp++;
            if (dirty_r !== dirty_m) begin
                n_bad++;
                $display("FAIL rnd_dirty: got %b want %b", dirty_r, dirty_m);
            end
            if ($urandom_range(1, 0) == 1) begin
                do_commit();
                model_commit();
                tick();
            end
            for (int i = 0; i < 6; i++) begin
                lut_in = 12'($urandom);
                #1;
                exp_o = model_out(lut_in);
                n_cmp++;
                if (out_c !== exp_o) begin
                    n_bad++;
                    $display("FAIL rnd_comb: in=%h got %b want %b", lut_in, out_c, exp_o);
                end
                tick();
                n_cmp++;
                if (out_r !== exp_o) begin
                    n_bad++;
                    $display("FAIL rnd_reg: in=%h got %b want %b", lut_in, out_r, exp_o);
                end
            end
        end
        do_commit();
        model_commit();
        tick();
        for (int i = 0; i < 6; i++) begin
            lut_in = 12'($urandom);
            tick();
            exp_o = model_out(lut_in);
            n_cmp++;
            if (out_r !== exp_o || out_c !== exp_o) begin
                n_bad++;
                $display("FAIL rnd_final: in=%h got r=%b c=%b want %b", lut_in, out_r, out_c, exp_o);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_and();
        test_load_stall();
        test_err();
        test_start_commit();
        test_reset_mid_load();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
